// File: rtl/hub75_line_capture.sv
// rtl/hub75_line_capture.sv - HUB75 panel-side receiver: oversample, rebuild line pair, drain as pixel writes
module hub75_line_capture #(
    parameter int COLS = 64,
    parameter int CW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hub_clk,
    input  logic          hub_lat,
    input  logic          hub_oe,
    input  logic [3:0]    hub_addr,
    input  logic [2:0]    hub_rgb0,
    input  logic [2:0]    hub_rgb1,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [4:0]    wr_row,
    output logic [CW-1:0] wr_col,
    output logic [2:0]    wr_rgb,
    output logic          line_done,
    output logic          frame_done,
    output logic          len_err,
    output logic          overrun,
    output logic [15:0]   oe_cycles
);
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    logic [12:0] r_sync1, r_sync2;
    logic        r_prev_clk, r_prev_lat;
    logic [8:0]  r_edges;
    logic [3:0]  r_addr, r_prev_addr;
    logic [5:0]  r_shift [COLS];
    logic [5:0]  r_line  [COLS];
    logic [5:0]  w_shift_next [COLS];

    logic          w_s_oe, w_clk_rise, w_lat_rise, w_next_half;
    logic [3:0]    w_s_addr;
    logic [5:0]    w_s_data;
    logic [8:0]    w_edges_next;
    logic [CW-1:0] w_next_col;

    // Every pin shares one synchronizer so data stays aligned with the detected edges
    always_ff @(posedge clk) begin
        r_sync1    <= {hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb0, hub_rgb1};
        r_sync2    <= r_sync1;
        r_prev_clk <= r_sync2[12];
        r_prev_lat <= r_sync2[11];
    end

    assign w_clk_rise   = r_sync2[12] & ~r_prev_clk;
    assign w_lat_rise   = r_sync2[11] & ~r_prev_lat;
    assign w_s_oe       = r_sync2[10];
    assign w_s_addr     = r_sync2[9:6];
    assign w_s_data     = r_sync2[5:0];
    assign w_edges_next = (w_clk_rise && r_edges != 9'd511) ? r_edges + 9'd1 : r_edges;
    assign w_next_col   = wr_col + CW'(1);
    assign w_next_half  = wr_row[4] | (wr_col == CW'(COLS - 1));

    always_comb begin
        for (int i = 0; i < COLS; i++) w_shift_next[i] = r_shift[i];
        if (w_clk_rise) begin
            w_shift_next[0] = w_s_data;
            for (int i = 1; i < COLS; i++) w_shift_next[i] = r_shift[i-1];
        end
    end

    // Latch copies the post-shift view so a coincident shift edge is not lost
    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
        if (w_lat_rise && r_state == S_IDLE) r_line <= w_shift_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_edges     <= 9'd0;
            r_addr      <= 4'd0;
            r_prev_addr <= 4'hF;
            wr_valid    <= 1'b0;
            wr_row      <= 5'd0;
            wr_col      <= '0;
            wr_rgb      <= 3'd0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
            overrun     <= 1'b0;
            oe_cycles   <= 16'd0;
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            r_edges    <= w_lat_rise ? 9'd0 : w_edges_next;
            if (w_lat_rise)
                oe_cycles <= 16'd0;
            else if (!w_s_oe && oe_cycles != 16'hFFFF)
                oe_cycles <= oe_cycles + 16'd1;
            if (w_lat_rise && w_edges_next != 9'(COLS)) len_err <= 1'b1;
            if (w_lat_rise && r_state != S_IDLE) overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_lat_rise) begin
                        r_addr   <= w_s_addr;
                        wr_valid <= 1'b1;
                        wr_row   <= {1'b0, w_s_addr};
                        wr_col   <= '0;
                        wr_rgb   <= w_shift_next[0][5:3];
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (wr_valid && wr_ready) begin
                        if (wr_row[4] && wr_col == CW'(COLS - 1)) begin
                            wr_valid    <= 1'b0;
                            line_done   <= 1'b1;
                            frame_done  <= (r_addr == 4'd0) && (r_prev_addr == 4'hF);
                            r_prev_addr <= r_addr;
                            r_state     <= S_DONE;
                        end else begin
                            wr_col <= w_next_col;
                            wr_row <= {w_next_half, r_addr};
                            wr_rgb <= w_next_half ? r_line[w_next_col][2:0]
                                                  : r_line[w_next_col][5:3];
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
